// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch
// requester and the data (load/store) requester.  One memory transaction is in
// flight at a time: IDLE arbitrates, ISSUE drives the memory strobe for one
// cycle, WAIT covers the memory latency, and the response is delivered as the
// FSM returns to IDLE.  Data wins by default; a saturating counter forces a
// fetch grant after STARVE_MAX consecutive data grants taken while fetch was
// waiting.  A flush during an in-flight fetch suppresses its response while the
// memory cycle itself still runs to completion.
//
// Ports
//   clk1, reset           : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_gnt
//   if_gnt                : one-cycle pulse, fetch accepted
//   if_rvalid/if_rdata    : fetch response pulse and held fetched word
//   flush                 : kill the response of an outstanding fetch
//   d_req/d_we/d_addr/d_wdata : data request, held until d_gnt
//   d_gnt                 : one-cycle pulse, data accepted
//   d_rvalid/d_rdata      : load data / store completion pulse, held load word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   busy                  : FSM is not in IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  // The latency counter is loaded with MEM_LAT-1 so WAIT lasts MEM_LAT cycles.
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [SC_W-1:0]    starve_q, starve_d;
  logic               owner_fetch_q, owner_fetch_d;
  logic               kill_q, kill_d;
  logic               if_gnt_q, if_gnt_d;
  logic               d_gnt_q, d_gnt_d;
  logic               if_rvalid_q, if_rvalid_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;

  logic               pick_fetch_s;
  logic               fetch_killed_s;

  // Fetch wins only when alone or when data has starved it for STARVE_MAX grants.
  assign pick_fetch_s   = if_req & (~d_req | (starve_q == STARVE_LIM));
  // A flush in the final WAIT cycle must already suppress the response.
  assign fetch_killed_s = kill_q | flush;

  // Next-state, arbitration and response capture.
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    starve_d      = starve_q;
    owner_fetch_d = owner_fetch_q;
    kill_d        = kill_q;
    if_gnt_d      = 1'b0;
    d_gnt_d       = 1'b0;
    if_rvalid_d   = 1'b0;
    d_rvalid_d    = 1'b0;
    mem_en_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        // Starvation bookkeeping only looks at what is pending in IDLE.
        if (!if_req) begin
          starve_d = {SC_W{1'b0}};
        end else if (pick_fetch_s) begin
          starve_d = {SC_W{1'b0}};
        end else if (starve_q != STARVE_LIM) begin
          starve_d = starve_q + SC_W'(1);
        end else begin
          starve_d = starve_q;
        end

        if (if_req || d_req) begin
          state_d  = ISSUE;
          kill_d   = 1'b0;
          mem_en_d = 1'b1;
          if (pick_fetch_s) begin
            owner_fetch_d = 1'b1;
            if_gnt_d      = 1'b1;
            mem_we_d      = 1'b0;
            mem_addr_d    = if_addr;
            mem_wdata_d   = {DATA_W{1'b0}};
          end else begin
            owner_fetch_d = 1'b0;
            d_gnt_d       = 1'b1;
            mem_we_d      = d_we;
            mem_addr_d    = d_addr;
            mem_wdata_d   = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_LOAD;
        if (flush && owner_fetch_q) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end

      WAIT: begin
        if (flush && owner_fetch_q) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end

        if (lat_q == {LAT_W{1'b0}}) begin
          state_d = IDLE;
          if (owner_fetch_q) begin
            if (!fetch_killed_s) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata;
            end else begin
              if_rvalid_d = 1'b0;
            end
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lat_q         <= {LAT_W{1'b0}};
      starve_q      <= {SC_W{1'b0}};
      owner_fetch_q <= 1'b0;
      kill_q        <= 1'b0;
      if_gnt_q      <= 1'b0;
      d_gnt_q       <= 1'b0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
      if_rdata_q    <= {DATA_W{1'b0}};
      d_rdata_q     <= {DATA_W{1'b0}};
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      starve_q      <= starve_d;
      owner_fetch_q <= owner_fetch_d;
      kill_q        <= kill_d;
      if_gnt_q      <= if_gnt_d;
      d_gnt_q       <= d_gnt_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter.  Requesters push the response they
// expect (computed from a shadow copy of memory) into per-port queues; a
// monitor pops and compares whenever the DUT presents if_rvalid or d_rvalid,
// and also checks grant/strobe/busy timing every cycle.  The bench also plays
// the role of the 1024x32 memory with a one-cycle read latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic              clk1;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              flush;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk1     (clk1),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .flush    (flush),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem     [1024];
  logic [DATA_W-1:0] ref_mem [1024];

  // Scoreboard queues: fetch words, and {is_store, load word} for data.
  logic [DATA_W-1:0] exp_if[$];
  logic [DATA_W:0]   exp_d[$];

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".if_gnt"},    if_gnt,    64'd0);
    check({tag, ".if_rvalid"}, if_rvalid, 64'd0);
    check({tag, ".if_rdata"},  if_rdata,  64'd0);
    check({tag, ".d_gnt"},     d_gnt,     64'd0);
    check({tag, ".d_rvalid"},  d_rvalid,  64'd0);
    check({tag, ".d_rdata"},   d_rdata,   64'd0);
    check({tag, ".mem_en"},    mem_en,    64'd0);
    check({tag, ".mem_we"},    mem_we,    64'd0);
    check({tag, ".mem_addr"},  mem_addr,  64'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 64'd0);
    check({tag, ".busy"},      busy,      64'd0);
  endtask

  // Memory model: preload, then one-cycle read latency, writes on the strobe edge.
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'h2A0000FF;
    ref_mem[16] = 32'h2A0000FF;
    forever begin
      @(posedge clk1);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Monitor: pops expected responses and checks per-cycle timing rules.
  initial begin
    int cyc;
    int last_gnt_cyc;
    int if_gnt_cyc;
    int d_gnt_cyc;
    bit gnt_seen;
    logic [DATA_W-1:0] last_if;
    logic [DATA_W-1:0] last_d;
    logic [DATA_W:0]   e_d;
    logic [DATA_W-1:0] e_if;
    logic              exp_busy;
    cyc = 0; last_gnt_cyc = 0; if_gnt_cyc = 0; d_gnt_cyc = 0; gnt_seen = 0;
    last_if = '0; last_d = '0;
    forever begin
      @(negedge clk1);
      if (reset) begin
        gnt_seen = 0;
        last_if  = '0;
        last_d   = '0;
      end else begin
        cyc++;
        check("gnt_exclusive", if_gnt & d_gnt, 64'd0);
        check("mem_en_with_gnt", mem_en, if_gnt | d_gnt);
        if (if_gnt) if_gnt_cyc = cyc;
        if (d_gnt)  d_gnt_cyc  = cyc;
        if (if_gnt | d_gnt) begin
          last_gnt_cyc = cyc;
          gnt_seen     = 1;
        end
        exp_busy = gnt_seen && ((cyc - last_gnt_cyc) <= MEM_LAT);
        check("busy", busy, exp_busy);

        if (if_rvalid) begin
          check("if_rvalid_expected", exp_if.size() != 0, 64'd1);
          if (exp_if.size() != 0) begin
            e_if = exp_if.pop_front();
            check("if_rdata", if_rdata, e_if);
            last_if = e_if;
          end
          check("if_rvalid_latency", cyc - if_gnt_cyc, MEM_LAT + 1);
        end else begin
          check("if_rdata_hold", if_rdata, last_if);
        end

        if (d_rvalid) begin
          check("d_rvalid_expected", exp_d.size() != 0, 64'd1);
          if (exp_d.size() != 0) begin
            e_d = exp_d.pop_front();
            if (!e_d[DATA_W]) last_d = e_d[DATA_W-1:0];
            check("d_rdata", d_rdata, last_d);
          end
          check("d_rvalid_latency", cyc - d_gnt_cyc, MEM_LAT + 1);
        end else begin
          check("d_rdata_hold", d_rdata, last_d);
        end
      end
    end
  end

  task automatic wait_if_gnt(output bit ok);
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (if_gnt) begin ok = 1; break; end
    end
    check("if_gnt_timeout", ok, 64'd1);
  endtask

  task automatic wait_d_gnt(output bit ok);
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (d_gnt) begin ok = 1; break; end
    end
    check("d_gnt_timeout", ok, 64'd1);
  endtask

  task automatic fetch_agent(input int n);
    bit ok;
    int gap;
    int when;
    logic [ADDR_W-1:0] a;
    bit kill;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      // flush while no fetch of ours is in flight must have no effect
      for (int g = 0; g < gap; g++) begin
        flush = ($urandom_range(0, 3) == 0);
        tick();
      end
      flush = 1'b0;
      a     = ADDR_W'($urandom_range(0, 511));
      kill  = ($urandom_range(0, 3) == 0);
      if (!kill) exp_if.push_back(ref_mem[a]);
      if_req  = 1'b1;
      if_addr = a;
      wait_if_gnt(ok);
      check("rnd_if_mem_addr", mem_addr, a);
      check("rnd_if_mem_we", mem_we, 64'd0);
      if_req = 1'b0;
      if (kill) begin
        when = $urandom_range(0, MEM_LAT);
        for (int c = 0; c <= MEM_LAT; c++) begin
          flush = (c == when);
          tick();
        end
        flush = 1'b0;
        check("rnd_killed_no_rvalid", if_rvalid, 64'd0);
      end else begin
        ok = 0;
        for (int t = 0; t < 10; t++) begin
          tick();
          if (if_rvalid) begin ok = 1; break; end
        end
        check("rnd_if_rvalid_timeout", ok, 64'd1);
      end
    end
  endtask

  task automatic data_agent(input int n);
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      we = 1'($urandom_range(0, 1));
      a  = ADDR_W'(512 + $urandom_range(0, 511));
      wd = $urandom;
      if (we) begin
        ref_mem[a] = wd;
        exp_d.push_back({1'b1, 32'h0});
      end else begin
        exp_d.push_back({1'b0, ref_mem[a]});
      end
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      wait_d_gnt(ok);
      check("rnd_d_mem_addr", mem_addr, a);
      check("rnd_d_mem_we", mem_we, we);
      if (we) check("rnd_d_mem_wdata", mem_wdata, wd);
      d_req = 1'b0;
      ok = 0;
      for (int t = 0; t < 10; t++) begin
        tick();
        if (d_rvalid) begin ok = 1; break; end
      end
      check("rnd_d_rvalid_timeout", ok, 64'd1);
    end
  endtask

  initial begin
    int k;
    bit ok;
    logic [DATA_W-1:0] last_fetch;
    logic [DATA_W-1:0] store_word;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) tick();

    // Reset held with random inputs: everything stays at zero.
    if_req = 1'($urandom_range(0, 1)); if_addr = ADDR_W'($urandom);
    d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = ADDR_W'($urandom);
    d_wdata = $urandom; flush = 1'($urandom_range(0, 1));
    #1;
    check_zero("reset_rand_in");
    tick();
    check_zero("reset_rand_in2");
    if_req = 1'b0; d_req = 1'b0; flush = 1'b0; d_we = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_zero("after_reset");

    // Single fetch of 0x010.
    if_req = 1'b1; if_addr = 10'h010;
    exp_if.push_back(32'h2A0000FF);
    tick();
    check("fetch_gnt", if_gnt, 64'd1);
    check("fetch_mem_en", mem_en, 64'd1);
    check("fetch_mem_addr", mem_addr, 64'h010);
    check("fetch_mem_we", mem_we, 64'd0);
    check("fetch_busy_c1", busy, 64'd1);
    if_req = 1'b0;
    tick();
    check("fetch_busy_c2", busy, 64'd1);
    check("fetch_mem_en_c2", mem_en, 64'd0);
    tick();
    check("fetch_rvalid_c3", if_rvalid, 64'd1);
    check("fetch_rdata_c3", if_rdata, 64'h2A0000FF);
    check("fetch_busy_c3", busy, 64'd0);
    tick();

    // Simultaneous fetch and store: data first, then fetch.
    if_req = 1'b1; if_addr = 10'h020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEADBEEF;
    ref_mem[10'h3FF] = 32'hDEADBEEF;
    exp_d.push_back({1'b1, 32'h0});
    exp_if.push_back(ref_mem[10'h020]);
    last_fetch = ref_mem[10'h020];
    tick();
    check("sim_d_gnt_c1", d_gnt, 64'd1);
    check("sim_if_gnt_c1", if_gnt, 64'd0);
    check("sim_mem_we", mem_we, 64'd1);
    check("sim_mem_addr", mem_addr, 64'h3FF);
    check("sim_mem_wdata", mem_wdata, 64'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
    check("sim_d_rvalid_c3", d_rvalid, 64'd1);
    check("sim_d_rdata_kept", d_rdata, 64'd0);
    tick();
    check("sim_if_gnt_c4", if_gnt, 64'd1);
    check("sim_if_addr_c4", mem_addr, 64'h020);
    if_req = 1'b0;
    tick();
    tick();
    check("sim_if_rvalid_c6", if_rvalid, 64'd1);
    tick();

    // Load back the stored word.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
    exp_d.push_back({1'b0, ref_mem[10'h3FF]});
    wait_d_gnt(ok);
    d_req = 1'b0;
    repeat (2) tick();
    check("load_back", d_rdata, 64'hDEADBEEF);
    tick();

    // Starvation: both held high, grant order D D D D IF repeating.
    if_req = 1'b1; if_addr = 10'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h250;
    k = 0;
    for (int t = 0; t < 60 && k < 10; t++) begin
      tick();
      if (d_gnt || if_gnt) begin
        check("starve_order", if_gnt, (k % 5) == 4);
        if (if_gnt) exp_if.push_back(ref_mem[10'h030]);
        else        exp_d.push_back({1'b0, ref_mem[10'h250]});
        if (if_gnt) last_fetch = ref_mem[10'h030];
        k++;
        if (k == 10) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    check("starve_grant_count", k, 64'd10);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // Flush of an in-flight fetch; a following data request proceeds normally.
    if_req = 1'b1; if_addr = 10'h040;
    tick();
    check("flush_if_gnt", if_gnt, 64'd1);
    check("flush_mem_en", mem_en, 64'd1);
    if_req = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_no_rvalid", if_rvalid, 64'd0);
    check("flush_rdata_kept", if_rdata, last_fetch);
    check("flush_busy_c3", busy, 64'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
    exp_d.push_back({1'b0, ref_mem[10'h3FF]});
    tick();
    check("flush_then_d_gnt", d_gnt, 64'd1);
    d_req = 1'b0;
    repeat (3) tick();

    // Reset asserted in the WAIT cycle of a load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h210;
    exp_d.push_back({1'b0, ref_mem[10'h210]});
    tick();
    check("rstmid_d_gnt", d_gnt, 64'd1);
    tick();
    reset = 1'b1;
    exp_d.delete();
    exp_if.delete();
    #1;
    check("rstmid_busy", busy, 64'd0);
    check("rstmid_d_rvalid", d_rvalid, 64'd0);
    check("rstmid_mem_en", mem_en, 64'd0);
    check("rstmid_d_rdata", d_rdata, 64'd0);
    tick();
    check("rstmid_held_d_rvalid", d_rvalid, 64'd0);
    reset = 1'b0;
    exp_d.push_back({1'b0, ref_mem[10'h210]});
    tick();
    check("rstmid_regrant", d_gnt, 64'd1);
    check("rstmid_mem_addr", mem_addr, 64'h210);
    d_req = 1'b0;
    repeat (4) tick();

    // Randomized concurrent traffic against the shadow memory.
    fork
      fetch_agent(40);
      data_agent(40);
    join
    repeat (6) tick();
    check("if_queue_drained", exp_if.size(), 64'd0);
    check("d_queue_drained", exp_d.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, wanted $finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port 1024x32 unified memory between the pipeline's instruction-fetch requester and its data (LW/SW) requester. Only one memory transaction is outstanding at a time. Data accesses have priority by default, bounded by an anti-starvation counter that protects fetch. A flush input discards the response of an in-flight fetch after a taken branch; the memory cycle itself still completes.

## Interface
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_en sample edge to mem_rdata valid (must be >= 1)
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending
- clk1  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; hold if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word; holds until the next if_rvalid
- flush  in  1  kills the response of an outstanding fetch
- d_req  in  1  data request; hold d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data; unchanged by stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: arbitrate requests.
  - ISSUE: exactly 1 cycle.
  - WAIT: exactly MEM_LAT cycles, timed by a down-counter.
- Transitions:
  - IDLE -> ISSUE when if_req or d_req is high.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> IDLE on the edge where the latency counter is 0.
- Arbitration (IDLE only, combinational on sampled requests):
  - Data wins unless starve_cnt == STARVE_MAX and if_req == 1.
  - A lone requester always wins.
  - The winner is recorded in an owner register.
- starve_cnt:
  - Increments when data is granted while if_req == 1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req == 0.
  - Saturates at STARVE_MAX; width is clog2(STARVE_MAX+1).
- On the IDLE->ISSUE edge, the arbiter registers:
  - mem_addr, mem_we, mem_wdata from the winner; mem_we = 0 for fetch.
  - The winner's gnt, asserted for the ISSUE cycle only.
  - mem_en = 1 for the ISSUE cycle only.
- mem_addr, mem_we and mem_wdata hold their values until the next ISSUE.
- On the WAIT->IDLE edge:
  - Owner = data: capture mem_rdata into d_rdata if load only; pulse d_rvalid.
  - Owner = fetch: capture mem_rdata into if_rdata and pulse if_rvalid, unless kill == 1.
- kill:
  - Set by flush == 1 in any ISSUE or WAIT cycle while owner = fetch.
  - Cleared on every IDLE->ISSUE edge.
  - flush is ignored in IDLE and for data transactions.
  - A killed fetch does not update if_rdata.
- A requester must drop req no later than its rvalid cycle; a req still high in IDLE is treated as a new request.
- Reset (asynchronous, effective immediately, including mid-transaction):
  - State = IDLE.
  - All outputs 0, including if_rdata and d_rdata.
  - starve_cnt = 0, kill = 0, latency counter = 0.
  - The in-flight transaction is abandoned; no rvalid is produced.

## Timing
- Request sampled in cycle 0 (IDLE) -> gnt and mem_en in cycle 1 -> mem_rdata valid in cycle 1+MEM_LAT -> rvalid in cycle 2+MEM_LAT.
- The rvalid cycle is an IDLE cycle, so the next request can be granted the cycle after rvalid.
- Throughput: one access per MEM_LAT+2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset:
  - Assert reset with random inputs -> all outputs 0, busy = 0.
  - Deassert reset -> outputs stay 0 until a request arrives.
- Single fetch (MEM_LAT = 1), mem[0x010] = 0x2A0000FF, if_req with if_addr = 0x010 in cycle 0:
  - if_gnt = mem_en = 1 in cycle 1, mem_addr = 0x010, mem_we = 0.
  - if_rvalid = 1 in cycle 3, if_rdata = 0x2A0000FF.
  - busy = 1 in cycles 1-2.
- Simultaneous requests, both in cycle 0; data is a store with d_addr = 0x3FF, d_wdata = 0xDEADBEEF:
  - d_gnt in cycle 1 with mem_we = 1, mem_addr = 0x3FF.
  - d_rvalid in cycle 3; d_rdata unchanged.
  - if_gnt in cycle 4; if_rvalid in cycle 6.
- Starvation, STARVE_MAX = 4: if_req held high while d_req re-asserts every IDLE:
  - Grant order D, D, D, D, IF, D, D, D, D, IF, ...
- Flush: fetch granted in cycle 1, flush = 1 in cycle 2:
  - mem_en still pulses in cycle 1.
  - No if_rvalid in cycle 3; if_rdata unchanged; busy = 0 in cycle 3.
  - A following d_req is granted normally.
- Reset mid-WAIT, reset asserted in cycle 2 of a load:
  - busy, d_rvalid and mem_en are 0 immediately.
  - After reset deasserts with d_req still high: d_gnt one cycle after the first IDLE sample, with correct data.
